// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Holds the loader state encoding and the default chain length.
package fpga_cfg_pkg;

    // Also used to size the fabric's configuration chain.
    localparam int CFG_CHAIN_LEN_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } cfg_state_t;

endpackage

// File: rtl/cfg_piso8.sv
// 8-bit parallel-in/serial-out register, MSB first, with bit index.
// Ports: clk_i, rst_ni, load_i, shift_i, din_i[7:0] -> msb_o, last_bit_o.
module cfg_piso8 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] din_i,
    output logic       msb_o,
    output logic       last_bit_o
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] idx_q, idx_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load_i) begin
            sr_d  = din_i;
            idx_d = '0;
        end else if (shift_i) begin
            sr_d  = {sr_q[6:0], 1'b0};
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign msb_o      = sr_q[7];
    // High while the eighth bit of the byte is on msb_o.
    assign last_bit_o = (idx_q == 3'd7);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Serializes bitstream bytes MSB-first into the fabric config chain,
// then strobes cfg_latch once CHAIN_LEN bits have been shifted.
// Ports: clk, rst_n, start, din[7:0], din_valid -> din_ready,
//        cfg_bit, cfg_shift, cfg_latch, busy, done.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = CFG_CHAIN_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       cfg_latch,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CHAIN_LEN - 1);

    cfg_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          piso_load, piso_shift;
    logic          piso_msb, piso_last;

    cfg_piso8 u_piso (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (piso_load),
        .shift_i    (piso_shift),
        .din_i      (din),
        .msb_o      (piso_msb),
        .last_bit_o (piso_last)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (din_valid) begin
                    piso_load = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                piso_shift = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                // Chain end wins over byte end: leftover bits are dropped.
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_COMMIT;
                end else if (piso_last) begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pure state decode, so reset clears every output at once.
    assign din_ready = (state_q == ST_LOAD);
    assign cfg_shift = (state_q == ST_SHIFT);
    assign cfg_bit   = cfg_shift & piso_msb;
    assign cfg_latch = (state_q == ST_COMMIT);
    assign busy      = din_ready | cfg_shift | cfg_latch;
    assign done      = (state_q == ST_DONE);

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Configuration writer for the FPGA-clone fabric. It accepts bitstream bytes from the chip pins over a valid/ready byte handshake and serializes them MSB-first into the fabric's configuration shift chain. After exactly `CHAIN_LEN` bits have been shifted, it pulses the fabric's latch strobe. It sits between `tt_um_top` pin decoding and the configuration chain that the fabric's logic cells read.

## Interface
**Parameters**
- `CHAIN_LEN`, default 64: total configuration bits in the fabric chain; must be ≥ 1.

**Ports**
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a configuration session; sampled only in IDLE or DONE.
- `din` input 8: bitstream byte; the first chain bit is `din[7]`.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: loader will accept `din` this cycle.
- `cfg_bit` output 1: serial data into the configuration chain.
- `cfg_shift` output 1: shift enable for the chain; the chain shifts `cfg_bit` in on every `clk` edge while high.
- `cfg_latch` output 1: one-cycle strobe that commits chain contents into the fabric.
- `busy` output 1: session in progress (LOAD, SHIFT or COMMIT).
- `done` output 1: last session completed; held high until the next `start`.

## Operation
- **States:** IDLE, LOAD, SHIFT, COMMIT, DONE.
- **IDLE / DONE**
  - `start`=1 → clear bit counter `cnt`, clear `done`, go to LOAD.
  - `start`=0 → stay.
- **LOAD**
  - `din_ready`=1.
  - `din_valid`=1 → capture `din` into an 8-bit shift register, clear bit index, go to SHIFT.
  - `din_valid`=0 → stay, with no timeout.
- **SHIFT**
  - `cfg_shift`=1 and `cfg_bit` = shift register MSB.
  - Each cycle: shift the register left, increment `cnt`, increment bit index.
  - If `cnt` reaches `CHAIN_LEN` on this bit, go to COMMIT. Any remaining bits of the byte are discarded; this is the partial-last-byte case when `CHAIN_LEN` is not a multiple of 8.
  - Otherwise, after the 8th bit, go to LOAD.
- **COMMIT**
  - `cfg_latch`=1 for exactly one cycle, then go to DONE.
- **Outputs by state**
  - `busy` = state ∈ {LOAD, SHIFT, COMMIT}.
  - `done` = state == DONE.
  - `din_ready` is high only in LOAD.
  - `cfg_bit` is 0 whenever `cfg_shift` is 0.
- **Counter width:** `cnt` is `$clog2(CHAIN_LEN+1)` bits and never exceeds `CHAIN_LEN`, so there is no wrap.
- **Boundary behaviour**
  - `start` during LOAD, SHIFT or COMMIT is ignored.
  - `din_valid` outside LOAD is ignored; the byte is not consumed.
  - `start` and `din_valid` both high in IDLE: only the state change to LOAD occurs; the byte is accepted in the following cycle if still valid.
  - `CHAIN_LEN`=1: one byte is accepted, one bit is shifted, then COMMIT.
- **Reset** (including mid-session): immediate return to IDLE.
  - All outputs go to 0: `din_ready`, `cfg_bit`, `cfg_shift`, `cfg_latch`, `busy`, `done`.
  - `cfg_latch` is never pulsed for an aborted session. Chain contents are don't-care.

## Timing
- `start` at edge t → LOAD from t+1; `din_ready` high from t+1.
- Byte accepted at edge a → `cfg_shift` high during cycles a+1 … a+8 for a full byte.
- Next LOAD begins at a+9, so throughput is 9 cycles per full byte with no bubble-free mode.
- The last bit is shifted in cycle L → `cfg_latch` high in cycle L+1 → `done` high from L+2.
- Total session length is `CHAIN_LEN` shift cycles plus `ceil(CHAIN_LEN/8)` load cycles (assuming `din_valid` is held high) plus 1 latch cycle.
- All outputs are registered or decoded purely from state; there is no combinational path from `din_valid` to `din_ready`.

## Structure
- Shared package `fpga_cfg_pkg` holds:
  - the state enum `cfg_state_t` (IDLE, LOAD, SHIFT, COMMIT, DONE);
  - the default chain length constant `CFG_CHAIN_LEN_DEFAULT` = 64, reused by the fabric chain.
- One sub-module, `cfg_piso8`: 8-bit parallel-in/serial-out register with `load`, `shift`, MSB output and a 3-bit bit index with an `last_bit` flag.
- The FSM, `cnt` and output decode live in `fpga_cfg_loader`.

## Test plan
- **Full byte session:** `CHAIN_LEN`=16, `start`, bytes 0xA5 then 0x3C with `din_valid` held high.
  - `cfg_bit` sequence is 1010_0101_0011_1100, with exactly 16 `cfg_shift` cycles.
  - `cfg_latch` pulses once; `done`=1 and `busy`=0 afterwards.
- **Partial last byte:** `CHAIN_LEN`=12, bytes 0xFF, 0x80.
  - Exactly 12 shifts: eight 1s, then 1,0,0,0.
  - `cfg_latch` fires immediately after the 12th shift; low nibble of 0x80 is never shifted.
- **Stalled source:** `CHAIN_LEN`=8, `din_valid` held low for 5 cycles after `start`.
  - `din_ready` stays high and `cfg_shift` stays 0 for those 5 cycles.
  - Byte 0x01 then gives 7 zeros and a 1, followed by `cfg_latch`.
- **Ignored events:** `CHAIN_LEN`=16, pulse `start` and `din_valid` mid-SHIFT.
  - No restart; the byte is not consumed; the bit sequence is unchanged.
  - Shift count at latch is 16.
- **Reset mid-session:** assert `rst_n`=0 during the 5th shift.
  - All outputs are 0 asynchronously and `cfg_latch` is never seen.
  - A new `start` after reset completes a clean 16-bit session.
- **Re-run from DONE:** a second `start` clears `done` next cycle and a second full session completes.
